// File: rtl/addsub_sequencer_pkg.sv
// rtl/addsub_sequencer_pkg.sv - shared constants and types for the nibble-serial add/sub sequencer
package addsub_sequencer_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Slice index width; a single-nibble build still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_subtractor.sv
// rtl/adder_subtractor.sv - 4-bit add/subtract slice with carry out and signed overflow
module adder_subtractor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  input  logic       M,
  output logic [3:0] SUM,
  output logic       CAR,
  output logic       V
);

  logic [3:0] w_b;
  logic [3:0] w_lo;
  logic [4:0] w_full;

  // Subtract inverts B; the caller supplies the +1 through CIN.
  assign w_b    = B ^ {4{M}};
  assign w_lo   = {1'b0, A[2:0]} + {1'b0, w_b[2:0]} + {3'b000, CIN};
  assign w_full = {1'b0, A} + {1'b0, w_b} + {4'b0000, CIN};

  assign SUM = w_full[3:0];
  assign CAR = w_full[4];
  assign V   = w_lo[3] ^ w_full[4];

endmodule

// File: rtl/addsub_sequencer.sv
// rtl/addsub_sequencer.sv - feeds wide operands one nibble per cycle through a single 4-bit slice
module addsub_sequencer
  import addsub_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic                        MODE,
  input  logic [NIBBLE_W*NIBBLES-1:0] OP_A,
  input  logic [NIBBLE_W*NIBBLES-1:0] OP_B,
  output logic                        READY,
  output logic                        DONE,
  output logic [NIBBLE_W*NIBBLES-1:0] RESULT,
  output logic                        COUT,
  output logic                        OVF
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t                r_state;
  logic [W-1:0]          r_opa;
  logic [W-1:0]          r_opb;
  logic                  r_mode;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_carry;
  logic [W-1:0]          r_result;
  logic                  r_cout;
  logic                  r_ovf;
  logic                  r_done;
  logic                  r_ready;

  logic [NIBBLE_W-1:0]   w_a;
  logic [NIBBLE_W-1:0]   w_b;
  logic [NIBBLE_W-1:0]   w_sum;
  logic                  w_car;
  logic                  w_v;

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IDX_W'(n)) begin
        w_a = r_opa[n*NIBBLE_W +: NIBBLE_W];
        w_b = r_opb[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  adder_subtractor u_slice (
    .A   (w_a),
    .B   (w_b),
    .CIN (r_carry),
    .M   (r_mode),
    .SUM (w_sum),
    .CAR (w_car),
    .V   (w_v)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_mode   <= MODE_ADD;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            r_opa   <= OP_A;
            r_opb   <= OP_B;
            r_mode  <= MODE;
            r_idx   <= '0;
            // Carry-in of 1 completes the two's-complement negate of B.
            r_carry <= (MODE == MODE_SUB);
            r_ready <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n)) begin
              r_result[n*NIBBLE_W +: NIBBLE_W] <= w_sum;
            end
          end
          r_carry <= w_car;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_car;
            r_ovf   <= w_v;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign READY  = r_ready;
  assign DONE   = r_done;
  assign RESULT = r_result;
  assign COUT   = r_cout;
  assign OVF    = r_ovf;

endmodule
